bnn_stream_feeder: RTL and testbench



---
 rtl/bnn_feed_pkg.sv | 44 ++++
 rtl/bnn_bit_rom.sv | 43 ++++
 rtl/bnn_stream_feeder.sv | 226 ++++++++++++++++++++++
 tb/tb_bnn_stream_feeder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_feed_pkg.sv
// Shared constants, config-select encodings and FSM state type for the BNN stream feeder.
package bnn_feed_pkg;

  localparam int unsigned IMG_PIXELS  = 784;
  localparam int unsigned PIX_THRESH  = 127;
  localparam int unsigned CONV0_DEPTH = 18;
  localparam int unsigned CONV1_DEPTH = 36;
  localparam int unsigned FC_DEPTH    = 338;
  localparam int unsigned FC_LANES    = 10;
  localparam int unsigned CFG_ADDR_W  = 9;

  // Bank-0 is split into two request phases of 9 bits each.
  localparam int unsigned CONV_PH0_END = 9;
  localparam int unsigned CONV_PH1_END = 18;

  localparam int unsigned PIX_CNT_W   = $clog2(IMG_PIXELS + 1);
  localparam int unsigned CONV_PTR_W  = $clog2(CONV0_DEPTH + 1);
  localparam int unsigned BANK1_PTR_W = $clog2(CONV1_DEPTH + 1);
  localparam int unsigned FC_PTR_W    = $clog2(FC_DEPTH + 1);

  localparam logic [3:0] SEL_FC0   = 4'd0;
  localparam logic [3:0] SEL_FC1   = 4'd1;
  localparam logic [3:0] SEL_FC2   = 4'd2;
  localparam logic [3:0] SEL_FC3   = 4'd3;
  localparam logic [3:0] SEL_FC4   = 4'd4;
  localparam logic [3:0] SEL_FC5   = 4'd5;
  localparam logic [3:0] SEL_FC6   = 4'd6;
  localparam logic [3:0] SEL_FC7   = 4'd7;
  localparam logic [3:0] SEL_FC8   = 4'd8;
  localparam logic [3:0] SEL_FC9   = 4'd9;
  localparam logic [3:0] SEL_CONV0 = 4'd10;
  localparam logic [3:0] SEL_CONV1 = 4'd11;

  localparam int unsigned ERR_UNDERRUN    = 0;
  localparam int unsigned ERR_CFG_BUSY    = 1;
  localparam int unsigned ERR_RES_OVERRUN = 2;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StWaitDone
  } feed_state_e;

endpackage

// File: rtl/bnn_bit_rom.sv
// Single-bit memory: one write port (address folded modulo depth), one registered read port.
module bnn_bit_rom #(
  parameter int unsigned Depth  = 18,
  parameter int unsigned AddrW  = $clog2(Depth),
  parameter int unsigned WAddrW = 9
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we,
  input  logic [WAddrW-1:0] waddr,
  input  logic              wdata,
  input  logic              re,
  input  logic [AddrW-1:0]  raddr,
  output logic              rdata
);

  localparam logic [WAddrW-1:0] DepthW = WAddrW'(Depth);

  logic              mem_q [Depth];
  logic [WAddrW-1:0] waddr_mod;
  logic              rdata_q;

  assign waddr_mod = waddr % DepthW;

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[AddrW'(waddr_mod)] <= wdata;
    end
  end

  // Registered read; output holds when no read is requested.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rdata_q <= 1'b0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/bnn_stream_feeder.sv
// Feeds a BNN accelerator: binarized pixel stream, conv/FC weight bits on request, result capture.
module bnn_stream_feeder
  import bnn_feed_pkg::*;
(
  input  logic                clk,
  input  logic                rstn,
  input  logic                run,
  output logic                busy,
  input  logic                cfg_we,
  input  logic [3:0]          cfg_sel,
  input  logic [8:0]          cfg_addr,
  input  logic                cfg_data,
  input  logic                pix_valid,
  input  logic [7:0]          pix_data,
  output logic                pix_ready,
  output logic                start,
  output logic                image_in,
  input  logic                weight_en_0,
  input  logic                weight_en_1,
  output logic                weight_conv_in,
  input  logic                fc_ivalid,
  output logic [FC_LANES-1:0] weight_fc_in,
  input  logic                done,
  input  logic [3:0]          classes_b,
  output logic                res_valid,
  output logic [3:0]          res_class,
  input  logic                res_ack,
  output logic [2:0]          err
);

  localparam logic [PIX_CNT_W-1:0]   PixLast   = PIX_CNT_W'(IMG_PIXELS - 1);
  localparam logic [CONV_PTR_W-1:0]  Ph0End    = CONV_PTR_W'(CONV_PH0_END);
  localparam logic [CONV_PTR_W-1:0]  Ph1End    = CONV_PTR_W'(CONV_PH1_END);
  localparam logic [BANK1_PTR_W-1:0] Bank1Last = BANK1_PTR_W'(CONV1_DEPTH - 1);
  localparam logic [FC_PTR_W-1:0]    FcLast    = FC_PTR_W'(FC_DEPTH - 1);
  localparam logic [7:0]             PixThresh = 8'(PIX_THRESH);

  feed_state_e state_q, state_d;

  logic [PIX_CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [CONV_PTR_W-1:0]  conv_ptr_q, conv_ptr_d;
  logic [BANK1_PTR_W-1:0] bank1_ptr_q, bank1_ptr_d;
  logic [FC_PTR_W-1:0]    fc_ptr_q, fc_ptr_d;
  logic                   conv_src_q, conv_src_d;
  logic                   start_q, start_d;
  logic                   image_in_q, image_in_d;
  logic                   done_q;
  logic                   res_valid_q, res_valid_d;
  logic [3:0]             res_class_q, res_class_d;
  logic [2:0]             err_q, err_d;

  logic                   run_go, pix_acc, cfg_ok, done_rise;
  logic                   conv0_re, conv1_re;
  logic                   conv0_rdata, conv1_rdata;
  logic [FC_LANES-1:0]    fc_rdata;

  assign busy      = (state_q != StIdle);
  assign pix_ready = (state_q == StStream);
  assign run_go    = run && (state_q == StIdle);
  assign pix_acc   = pix_valid && pix_ready;
  assign cfg_ok    = cfg_we && !busy;
  assign done_rise = done && !done_q;

  // Next-state logic for the inference sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (run) state_d = StStream;
      StStream:   if (pix_acc && (pix_cnt_q == PixLast)) state_d = StWaitDone;
      StWaitDone: if (done_rise) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Pixel binarization, start flag and sticky error flags.
  always_comb begin
    pix_cnt_d  = pix_cnt_q;
    start_d    = start_q;
    image_in_d = image_in_q;
    err_d      = err_q;
    if (run_go) begin
      pix_cnt_d = '0;
      err_d     = '0;
    end else begin
      if (pix_acc) begin
        pix_cnt_d  = pix_cnt_q + 1'b1;
        image_in_d = (pix_data > PixThresh);
        start_d    = 1'b1;
      end
      // The accelerator expects a pixel every cycle once streaming has begun.
      if ((state_q == StStream) && start_q && !pix_valid) err_d[ERR_UNDERRUN] = 1'b1;
      if (cfg_we && busy) err_d[ERR_CFG_BUSY] = 1'b1;
      if (done_rise && res_valid_q && !res_ack) err_d[ERR_RES_OVERRUN] = 1'b1;
    end
    if (state_q != StStream) start_d = 1'b0;
  end

  // Conv weight sequencing: bank0 in two phases, then bank1 cyclically.
  always_comb begin
    conv0_re    = 1'b0;
    conv1_re    = 1'b0;
    conv_ptr_d  = conv_ptr_q;
    bank1_ptr_d = bank1_ptr_q;
    conv_src_d  = conv_src_q;
    if (weight_en_0 && (conv_ptr_q < Ph0End)) begin
      conv0_re   = 1'b1;
      conv_ptr_d = conv_ptr_q + 1'b1;
      conv_src_d = 1'b0;
    end else if (weight_en_1 && (conv_ptr_q < Ph1End)) begin
      conv0_re   = 1'b1;
      conv_ptr_d = conv_ptr_q + 1'b1;
      conv_src_d = 1'b0;
    end else if (weight_en_0 || weight_en_1) begin
      conv1_re    = 1'b1;
      conv_src_d  = 1'b1;
      bank1_ptr_d = (bank1_ptr_q == Bank1Last) ? '0 : bank1_ptr_q + 1'b1;
    end
    if (run_go) begin
      conv_ptr_d  = '0;
      bank1_ptr_d = '0;
    end
  end

  // FC pointer advances on each request and wraps at the lane depth.
  always_comb begin
    fc_ptr_d = fc_ptr_q;
    if (fc_ivalid) fc_ptr_d = (fc_ptr_q == FcLast) ? '0 : fc_ptr_q + 1'b1;
    if (run_go) fc_ptr_d = '0;
  end

  // Result capture; a new capture wins over a same-cycle acknowledge.
  always_comb begin
    res_valid_d = res_valid_q;
    res_class_d = res_class_q;
    if (done_rise) begin
      res_valid_d = 1'b1;
      res_class_d = classes_b;
    end else if (res_ack) begin
      res_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= StIdle;
      pix_cnt_q   <= '0;
      conv_ptr_q  <= '0;
      bank1_ptr_q <= '0;
      fc_ptr_q    <= '0;
      conv_src_q  <= 1'b0;
      start_q     <= 1'b0;
      image_in_q  <= 1'b0;
      done_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_class_q <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      conv_ptr_q  <= conv_ptr_d;
      bank1_ptr_q <= bank1_ptr_d;
      fc_ptr_q    <= fc_ptr_d;
      conv_src_q  <= conv_src_d;
      start_q     <= start_d;
      image_in_q  <= image_in_d;
      done_q      <= done;
      res_valid_q <= res_valid_d;
      res_class_q <= res_class_d;
      err_q       <= err_d;
    end
  end

  bnn_bit_rom #(
    .Depth  (CONV0_DEPTH),
    .WAddrW (CFG_ADDR_W)
  ) u_conv0_rom (
    .clk   (clk),
    .rstn  (rstn),
    .we    (cfg_ok && (cfg_sel == SEL_CONV0)),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .re    (conv0_re),
    .raddr (conv_ptr_q),
    .rdata (conv0_rdata)
  );

  bnn_bit_rom #(
    .Depth  (CONV1_DEPTH),
    .WAddrW (CFG_ADDR_W)
  ) u_conv1_rom (
    .clk   (clk),
    .rstn  (rstn),
    .we    (cfg_ok && (cfg_sel == SEL_CONV1)),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .re    (conv1_re),
    .raddr (bank1_ptr_q),
    .rdata (conv1_rdata)
  );

  for (genvar k = 0; k < FC_LANES; k++) begin : g_fc_lane
    bnn_bit_rom #(
      .Depth  (FC_DEPTH),
      .WAddrW (CFG_ADDR_W)
    ) u_fc_rom (
      .clk   (clk),
      .rstn  (rstn),
      .we    (cfg_ok && (cfg_sel == 4'(k))),
      .waddr (cfg_addr),
      .wdata (cfg_data),
      .re    (fc_ivalid),
      .raddr (fc_ptr_q),
      .rdata (fc_rdata[k])
    );
  end

  assign weight_conv_in = conv_src_q ? conv1_rdata : conv0_rdata;
  assign weight_fc_in   = fc_rdata;
  assign start          = start_q;
  assign image_in       = image_in_q;
  assign res_valid      = res_valid_q;
  assign res_class      = res_class_q;
  assign err            = err_q;

endmodule

// File: tb/tb_bnn_stream_feeder.sv
// Directed plus randomized bench for bnn_stream_feeder against a behavioural model.
module tb_bnn_stream_feeder;

  logic       clk = 1'b0;
  logic       rstn, run, cfg_we, cfg_data, pix_valid;
  logic [3:0] cfg_sel;
  logic [8:0] cfg_addr;
  logic [7:0] pix_data;
  logic       busy, pix_ready, start, image_in;
  logic       weight_en_0, weight_en_1, weight_conv_in, fc_ivalid;
  logic [9:0] weight_fc_in;
  logic       done, res_ack, res_valid;
  logic [3:0] classes_b, res_class;
  logic [2:0] err;

  bnn_stream_feeder dut (
    .clk            (clk),
    .rstn           (rstn),
    .run            (run),
    .busy           (busy),
    .cfg_we         (cfg_we),
    .cfg_sel        (cfg_sel),
    .cfg_addr       (cfg_addr),
    .cfg_data       (cfg_data),
    .pix_valid      (pix_valid),
    .pix_data       (pix_data),
    .pix_ready      (pix_ready),
    .start          (start),
    .image_in       (image_in),
    .weight_en_0    (weight_en_0),
    .weight_en_1    (weight_en_1),
    .weight_conv_in (weight_conv_in),
    .fc_ivalid      (fc_ivalid),
    .weight_fc_in   (weight_fc_in),
    .done           (done),
    .classes_b      (classes_b),
    .res_valid      (res_valid),
    .res_class      (res_class),
    .res_ack        (res_ack),
    .err            (err)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit         m_conv0 [18];
  bit         m_conv1 [36];
  bit         m_fc    [10][338];
  int         c0_used, b1_pos, fc_pos;
  bit         conv_exp, img_exp;
  logic [9:0] fc_exp;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"},      32'(busy), 32'd0);
    check({tag, " pix_ready"}, 32'(pix_ready), 32'd0);
    check({tag, " start"},     32'(start), 32'd0);
    check({tag, " image_in"},  32'(image_in), 32'd0);
    check({tag, " conv"},      32'(weight_conv_in), 32'd0);
    check({tag, " fc"},        32'(weight_fc_in), 32'd0);
    check({tag, " res_valid"}, 32'(res_valid), 32'd0);
    check({tag, " res_class"}, 32'(res_class), 32'd0);
    check({tag, " err"},       32'(err), 32'd0);
  endtask

  task automatic cfg_write(input logic [3:0] sel, input logic [8:0] addr, input logic d);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic model_clear();
    c0_used = 0; b1_pos = 0; fc_pos = 0;
  endtask

  task automatic conv_cycle(input bit e0, input bit e1);
    weight_en_0 = e0; weight_en_1 = e1;
    tick();
    if (e0 && c0_used < 9) begin
      conv_exp = m_conv0[c0_used]; c0_used++;
    end else if (e1 && c0_used < 18) begin
      conv_exp = m_conv0[c0_used]; c0_used++;
    end else if (e0 || e1) begin
      conv_exp = m_conv1[b1_pos]; b1_pos = (b1_pos + 1) % 36;
    end
    check("conv bit", 32'(weight_conv_in), 32'(conv_exp));
    weight_en_0 = 1'b0; weight_en_1 = 1'b0;
  endtask

  task automatic fc_cycle(input bit v);
    fc_ivalid = v;
    tick();
    if (v) begin
      for (int k = 0; k < 10; k++) fc_exp[k] = m_fc[k][fc_pos];
      fc_pos = (fc_pos + 1) % 338;
    end
    check("fc bits", 32'(weight_fc_in), 32'(fc_exp));
    fc_ivalid = 1'b0;
  endtask

  task automatic pulse_run();
    run = 1'b1;
    tick();
    run = 1'b0;
    model_clear();
  endtask

  task automatic pulse_done(input logic [3:0] cls, input logic ack);
    classes_b = cls; done = 1'b1; res_ack = ack;
    tick();
    done = 1'b0; res_ack = 1'b0;
  endtask

  initial begin
    logic [17:0] b0;
    logic [7:0]  pd;
    bit          v, gap_seen;
    int          accepted;
    logic [3:0]  cls;

    rstn = 1'b0; run = 1'b0; cfg_we = 1'b0; cfg_sel = '0; cfg_addr = '0; cfg_data = 1'b0;
    pix_valid = 1'b0; pix_data = '0; weight_en_0 = 1'b0; weight_en_1 = 1'b0;
    fc_ivalid = 1'b0; done = 1'b0; classes_b = '0; res_ack = 1'b0;
    conv_exp = 1'b0; img_exp = 1'b0; fc_exp = '0;
    model_clear();
    tick(); tick();
    check_all_zero("reset");
    rstn = 1'b1;
    tick();

    // Memory load; bank0 bit 5 goes through an aliased address (23 mod 18).
    b0 = 18'h2AAAA;
    for (int i = 0; i < 18; i++) begin
      m_conv0[i] = b0[i];
      cfg_write(4'd10, (i == 5) ? 9'd23 : 9'(i), b0[i]);
    end
    for (int i = 0; i < 36; i++) begin
      m_conv1[i] = (i % 2) == 1;
      cfg_write(4'd11, 9'(i), m_conv1[i]);
    end
    for (int k = 0; k < 10; k++) begin
      for (int a = 0; a < 338; a++) begin
        m_fc[k][a] = (k == 3) ? 1'b1 : ((a % 2) == 1);
        cfg_write(4'(k), 9'(a), m_fc[k][a]);
      end
    end
    cfg_write(4'd12, 9'd0, 1'b1);
    check("idle cfg no err", 32'(err), 32'd0);

    // Conv sequencing: 12x phase0, then phase1, then bank1 continues; random tail.
    for (int i = 0; i < 12; i++) conv_cycle(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) conv_cycle(1'b0, 1'b1);
    conv_cycle(1'b0, 1'b0);
    conv_cycle(1'b0, 1'b0);
    for (int i = 0; i < 60; i++) conv_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // FC wrap and hold.
    for (int i = 0; i < 338 + 2; i++) fc_cycle(1'b1);
    for (int i = 0; i < 4; i++) fc_cycle(1'b0);
    for (int i = 0; i < 30; i++) fc_cycle(1'($urandom_range(0, 1)));

    // Image 1: alternating 127/128 with a config write, an ignored run, and an underrun.
    pulse_run();
    check("run busy", 32'(busy), 32'd1);
    check("run pix_ready", 32'(pix_ready), 32'd1);
    check("run start low", 32'(start), 32'd0);
    check("run err clear", 32'(err), 32'd0);
    for (int i = 0; i < 784; i++) begin
      if (i == 300) begin
        pix_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
          tick();
          check("underrun hold", 32'(image_in), 32'(img_exp));
        end
        check("underrun err0", 32'(err[0]), 32'd1);
      end
      pd = ((i % 2) == 1) ? 8'd128 : 8'd127;
      pix_valid = 1'b1; pix_data = pd;
      cfg_we = (i == 100); cfg_sel = 4'd10; cfg_addr = 9'd0; cfg_data = 1'b1;
      run = (i == 200);
      if (i == 783) check("pix_ready before last", 32'(pix_ready), 32'd1);
      tick();
      cfg_we = 1'b0; run = 1'b0;
      img_exp = (pd > 8'd127);
      check("image_in", 32'(image_in), 32'(img_exp));
      if (i < 783) check("start high", 32'(start), 32'd1);
      if (i == 100) check("cfg busy err1", 32'(err[1]), 32'd1);
      if (i == 200) check("run while busy", 32'(err), 32'b010);
    end
    pix_valid = 1'b0;
    check("wait_done pix_ready", 32'(pix_ready), 32'd0);
    check("wait_done busy", 32'(busy), 32'd1);
    tick(); tick();
    check("start dropped", 32'(start), 32'd0);
    check("img1 err", 32'(err), 32'b011);

    // Result handshake.
    pulse_done(4'd7, 1'b0);
    check("cap1 valid", 32'(res_valid), 32'd1);
    check("cap1 class", 32'(res_class), 32'd7);
    check("cap1 idle", 32'(busy), 32'd0);
    check("cap1 no ovr", 32'(err[2]), 32'd0);
    tick();
    pulse_done(4'd2, 1'b0);
    check("cap2 class", 32'(res_class), 32'd2);
    check("cap2 overrun", 32'(err[2]), 32'd1);
    tick();
    res_ack = 1'b1; tick(); res_ack = 1'b0;
    check("ack clears", 32'(res_valid), 32'd0);
    pulse_done(4'd5, 1'b0);
    check("cap3 valid", 32'(res_valid), 32'd1);
    tick();
    pulse_done(4'd9, 1'b1);
    check("cap+ack valid", 32'(res_valid), 32'd1);
    check("cap+ack class", 32'(res_class), 32'd9);
    tick();

    // Image 2: dropped write check, then reset mid-stream.
    pulse_run();
    check("run2 err clear", 32'(err), 32'd0);
    conv_cycle(1'b1, 1'b0);
    check("busy write dropped", 32'(weight_conv_in), 32'd0);
    conv_cycle(1'b1, 1'b0);
    fc_cycle(1'b1);
    for (int i = 0; i < 400; i++) begin
      pd = 8'($urandom_range(0, 255));
      pix_valid = 1'b1; pix_data = pd;
      cfg_we = (i == 50); cfg_sel = 4'd11; cfg_addr = 9'd0; cfg_data = 1'b1;
      tick();
      cfg_we = 1'b0;
      img_exp = (pd > 8'd127);
      check("image_in rand", 32'(image_in), 32'(img_exp));
    end
    check("pre-reset res_valid", 32'(res_valid), 32'd1);
    check("pre-reset err", 32'(err), 32'b010);
    rstn = 1'b0;
    tick();
    check_all_zero("mid reset");
    rstn = 1'b1; pix_valid = 1'b0;
    model_clear();
    conv_exp = 1'b0; fc_exp = '0; img_exp = 1'b0;
    tick();

    // Image 3: restart from pixel 0 with random gaps and random weight requests.
    pulse_run();
    for (int i = 0; i < 40; i++) conv_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 40; i++) fc_cycle(1'($urandom_range(0, 1)));
    accepted = 0; gap_seen = 1'b0;
    for (int i = 0; i < 2000 && accepted < 784; i++) begin
      check("stream pix_ready", 32'(pix_ready), 32'd1);
      v = ($urandom_range(0, 7) != 0);
      pd = 8'($urandom_range(0, 255));
      pix_valid = v; pix_data = pd;
      tick();
      if (v) begin
        accepted++;
        img_exp = (pd > 8'd127);
      end else if (accepted > 0) begin
        gap_seen = 1'b1;
      end
      check("image_in gaps", 32'(image_in), 32'(img_exp));
    end
    pix_valid = 1'b0;
    check("img3 accepted", 32'(accepted), 32'd784);
    check("img3 pix_ready low", 32'(pix_ready), 32'd0);
    check("img3 err", 32'(err), 32'(gap_seen));
    tick();
    cls = 4'($urandom_range(0, 15));
    pulse_done(cls, 1'b0);
    check("img3 class", 32'(res_class), 32'(cls));
    check("img3 valid", 32'(res_valid), 32'd1);
    check("img3 idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
